// File: rtl/floppy_sector_fetch.sv
// floppy_sector_fetch
//
// Device-side sector server for the WD1793 host emulation. Watches the
// cpu_command / cpu_status handshake, turns track/side/sector into a byte
// offset in a flat disk image and copies the requested bytes into the shared
// sector buffer. Serves READ (SECTOR_SIZE data bytes) and READADDR (6-byte ID).
//
// Ports:
//   clk, clken, reset_n    clock, clock enable, async active-low reset
//   cpu_command[7:0]       [7:4] 1=READ 3=READADDR 8=ACK, [0]=side
//   track, sector          controller track / sector registers
//   cpu_status[7:0]        [0]=done [1]=success
//   img_addr/img_rd        disk image read request, held until img_ack
//   img_ack/img_data       read completion with data in the same cycle
//   buff_addr/buff_wr/buff_odata  sector buffer write port
module floppy_sector_fetch #(
    parameter int unsigned SECTOR_SIZE       = 512,
    parameter int unsigned SECTORS_PER_TRACK = 10,
    parameter int unsigned SIDES             = 2,
    parameter int unsigned TRACKS            = 80
) (
    input  logic        clk,
    input  logic        clken,
    input  logic        reset_n,
    input  logic [7:0]  cpu_command,
    input  logic [7:0]  track,
    input  logic [7:0]  sector,
    output logic [7:0]  cpu_status,
    output logic [19:0] img_addr,
    output logic        img_rd,
    input  logic        img_ack,
    input  logic [7:0]  img_data,
    output logic [8:0]  buff_addr,
    output logic        buff_wr,
    output logic [7:0]  buff_odata
);

    localparam logic [8:0] LastIdx    = 9'(SECTOR_SIZE - 1);
    localparam logic [8:0] LastIdIdx  = 9'd5;
    localparam logic [3:0] CodeRead   = 4'h1;
    localparam logic [3:0] CodeRdAddr = 4'h3;
    localparam logic [7:0] CmdAck     = 8'h80;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StFetch,
        StWrite,
        StAddr,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  track_q, track_d;
    logic [7:0]  sector_q, sector_d;
    logic        side_q, side_d;
    logic        is_addr_q, is_addr_d;
    logic [19:0] base_q, base_d;
    logic [8:0]  idx_q, idx_d;
    logic [7:0]  status_q, status_d;
    logic [19:0] img_addr_q, img_addr_d;
    logic        img_rd_q, img_rd_d;
    logic [8:0]  buff_addr_q, buff_addr_d;
    logic        buff_wr_q, buff_wr_d;
    logic [7:0]  buff_odata_q, buff_odata_d;

    logic        req_valid;
    logic [19:0] lba;
    logic [19:0] base_calc;
    logic [8:0]  next_idx;
    logic [7:0]  id_byte;

    // Request decode works on the latched copies so mid-transfer command or
    // register changes cannot disturb the transfer.
    always_comb begin
        req_valid = (32'(track_q) < TRACKS) && (sector_q != 8'd0) &&
                    (32'(sector_q) <= SECTORS_PER_TRACK) && (32'(side_q) < SIDES);
        lba       = (20'(track_q) * 20'(SIDES) + 20'(side_q)) * 20'(SECTORS_PER_TRACK) +
                    20'(sector_q) - 20'd1;
        base_calc = lba * 20'(SECTOR_SIZE);
    end

    // ID field byte for the next READADDR slot.
    always_comb begin
        next_idx = idx_q + 9'd1;
        case (next_idx[2:0])
            3'd1:    id_byte = {7'd0, side_q};
            3'd2:    id_byte = sector_q;
            3'd3:    id_byte = 8'h02;
            default: id_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        track_d      = track_q;
        sector_d     = sector_q;
        side_d       = side_q;
        is_addr_d    = is_addr_q;
        base_d       = base_q;
        idx_d        = idx_q;
        status_d     = status_q;
        img_addr_d   = img_addr_q;
        img_rd_d     = img_rd_q;
        buff_addr_d  = buff_addr_q;
        buff_wr_d    = buff_wr_q;
        buff_odata_d = buff_odata_q;

        if (clken) begin
            // Write strobe lives for exactly one enabled cycle.
            buff_wr_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    status_d = 8'h00;
                    if (cpu_command[7:4] == CodeRead || cpu_command[7:4] == CodeRdAddr) begin
                        track_d   = track;
                        sector_d  = sector;
                        side_d    = cpu_command[0];
                        is_addr_d = (cpu_command[7:4] == CodeRdAddr);
                        state_d   = StCheck;
                    end
                end
                StCheck: begin
                    idx_d = 9'd0;
                    if (!req_valid) begin
                        status_d = 8'h01;
                        state_d  = StDone;
                    end else if (is_addr_q) begin
                        // First ID byte goes out on entry to StAddr.
                        buff_wr_d    = 1'b1;
                        buff_addr_d  = 9'd0;
                        buff_odata_d = track_q;
                        state_d      = StAddr;
                    end else begin
                        base_d     = base_calc;
                        img_addr_d = base_calc;
                        img_rd_d   = 1'b1;
                        state_d    = StFetch;
                    end
                end
                StFetch: begin
                    if (img_ack) begin
                        buff_odata_d = img_data;
                        buff_addr_d  = idx_q;
                        buff_wr_d    = 1'b1;
                        img_rd_d     = 1'b0;
                        state_d      = StWrite;
                    end
                end
                StWrite: begin
                    if (idx_q == LastIdx) begin
                        status_d = 8'h03;
                        state_d  = StDone;
                    end else begin
                        idx_d      = next_idx;
                        img_addr_d = base_q + 20'(next_idx);
                        img_rd_d   = 1'b1;
                        state_d    = StFetch;
                    end
                end
                StAddr: begin
                    if (idx_q == LastIdIdx) begin
                        status_d = 8'h03;
                        state_d  = StDone;
                    end else begin
                        idx_d        = next_idx;
                        buff_wr_d    = 1'b1;
                        buff_addr_d  = next_idx;
                        buff_odata_d = id_byte;
                    end
                end
                StDone: begin
                    // Only an explicit ACK re-arms; a lingering request is ignored.
                    if (cpu_command == CmdAck) begin
                        status_d = 8'h00;
                        state_d  = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            track_q      <= 8'd0;
            sector_q     <= 8'd0;
            side_q       <= 1'b0;
            is_addr_q    <= 1'b0;
            base_q       <= 20'd0;
            idx_q        <= 9'd0;
            status_q     <= 8'h00;
            img_addr_q   <= 20'd0;
            img_rd_q     <= 1'b0;
            buff_addr_q  <= 9'd0;
            buff_wr_q    <= 1'b0;
            buff_odata_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            track_q      <= track_d;
            sector_q     <= sector_d;
            side_q       <= side_d;
            is_addr_q    <= is_addr_d;
            base_q       <= base_d;
            idx_q        <= idx_d;
            status_q     <= status_d;
            img_addr_q   <= img_addr_d;
            img_rd_q     <= img_rd_d;
            buff_addr_q  <= buff_addr_d;
            buff_wr_q    <= buff_wr_d;
            buff_odata_q <= buff_odata_d;
        end
    end

    assign cpu_status = status_q;
    assign img_addr   = img_addr_q;
    assign img_rd     = img_rd_q;
    assign buff_addr  = buff_addr_q;
    assign buff_wr    = buff_wr_q;
    assign buff_odata = buff_odata_q;

endmodule

// File: tb/tb_floppy_sector_fetch.sv
// Bench for floppy_sector_fetch: scoreboard of expected image fetches and
// buffer writes, filled when a request is issued and drained by a monitor.
module tb_floppy_sector_fetch;

    logic        clk = 1'b0;
    logic        clken;
    logic        reset_n;
    logic [7:0]  cpu_command;
    logic [7:0]  cpu_command_s1;
    logic [7:0]  track;
    logic [7:0]  sector;
    logic [7:0]  cpu_status;
    logic [7:0]  cpu_status_s1;
    logic [19:0] img_addr;
    logic [19:0] img_addr_s1;
    logic        img_rd;
    logic        img_rd_s1;
    logic        img_ack;
    logic [7:0]  img_data;
    logic [8:0]  buff_addr;
    logic [8:0]  buff_addr_s1;
    logic        buff_wr;
    logic        buff_wr_s1;
    logic [7:0]  buff_odata;
    logic [7:0]  buff_odata_s1;

    int checks = 0;
    int errors = 0;
    int rd_seen = 0;
    int wr_seen = 0;
    bit mon_en = 1'b0;
    bit stress = 1'b0;

    logic [16:0] exp_wr_q[$];
    logic [19:0] exp_fetch_q[$];

    // Disk image content: byte value equals low address byte.
    assign img_data = img_addr[7:0];

    always #5 clk = ~clk;

    floppy_sector_fetch dut (
        .clk(clk), .clken(clken), .reset_n(reset_n), .cpu_command(cpu_command),
        .track(track), .sector(sector), .cpu_status(cpu_status), .img_addr(img_addr),
        .img_rd(img_rd), .img_ack(img_ack), .img_data(img_data), .buff_addr(buff_addr),
        .buff_wr(buff_wr), .buff_odata(buff_odata)
    );

    floppy_sector_fetch #(.SIDES(1)) dut_s1 (
        .clk(clk), .clken(clken), .reset_n(reset_n), .cpu_command(cpu_command_s1),
        .track(track), .sector(sector), .cpu_status(cpu_status_s1), .img_addr(img_addr_s1),
        .img_rd(img_rd_s1), .img_ack(img_ack), .img_data(img_data),
        .buff_addr(buff_addr_s1), .buff_wr(buff_wr_s1), .buff_odata(buff_odata_s1)
    );

    // clken pattern and memory responder, updated 1 time unit after each edge.
    initial begin
        int  age;
        int  phase;
        bit  en_last;
        bit  rd_last;
        age = 0; phase = 0; en_last = 1'b0; rd_last = 1'b0;
        clken = 1'b1; img_ack = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (en_last && rd_last) age++;
            if (!img_rd) age = 0;
            img_ack = stress ? (age >= 3) : 1'b1;
            phase = (phase + 1) % 4;
            clken = stress ? (phase == 0) : 1'b1;
            en_last = clken;
            rd_last = img_rd;
        end
    end

    // Monitor: outputs sampled on the falling edge; clken here equals the
    // value the DUT sees at the next rising edge.
    initial begin
        bit          hold_pending;
        logic [19:0] hold_addr;
        logic [16:0] exp_w;
        logic [19:0] exp_f;
        hold_pending = 1'b0;
        hold_addr = 20'd0;
        forever begin
            @(negedge clk);
            if (img_rd) rd_seen++;
            if (clken && buff_wr) wr_seen++;
            if (mon_en) begin
                if (clken && buff_wr) begin
                    checks++;
                    if (exp_wr_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write addr=%0h data=%0h required=none",
                                 buff_addr, buff_odata);
                    end else begin
                        exp_w = exp_wr_q.pop_front();
                        if ({buff_addr, buff_odata} !== exp_w) begin
                            errors++;
                            $display("FAIL buff_write got addr=%0h data=%0h required addr=%0h data=%0h",
                                     buff_addr, buff_odata, exp_w[16:8], exp_w[7:0]);
                        end
                    end
                end
                if (clken && img_rd && img_ack) begin
                    checks++;
                    if (exp_fetch_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_fetch addr=%0h required=none", img_addr);
                    end else begin
                        exp_f = exp_fetch_q.pop_front();
                        if (img_addr !== exp_f) begin
                            errors++;
                            $display("FAIL img_addr got %0h required %0h", img_addr, exp_f);
                        end
                    end
                end
                if (hold_pending) begin
                    checks++;
                    if (img_rd !== 1'b1 || img_addr !== hold_addr) begin
                        errors++;
                        $display("FAIL rd_hold got rd=%0b addr=%0h required rd=1 addr=%0h",
                                 img_rd, img_addr, hold_addr);
                    end
                end
                hold_pending = img_rd && !(clken && img_ack);
                hold_addr = img_addr;
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    function automatic logic [19:0] base_of(input logic [7:0] trk, input logic [7:0] sec,
                                            input logic side);
        int lba;
        lba = (int'(trk) * 2 + int'(side)) * 10 + int'(sec) - 1;
        return 20'(lba * 512);
    endfunction

    task automatic push_read(input logic [7:0] trk, input logic [7:0] sec, input logic side);
        logic [19:0] b;
        logic [19:0] a;
        b = base_of(trk, sec, side);
        for (int k = 0; k < 512; k++) begin
            a = b + 20'(k);
            exp_fetch_q.push_back(a);
            exp_wr_q.push_back({9'(k), a[7:0]});
        end
    endtask

    // Issue a request, wait for done, check status/latency/traffic. Leaves the
    // command asserted so callers can probe DONE behaviour.
    task automatic run_cmd(input string name, input logic [7:0] cmd, input logic [7:0] trk,
                           input logic [7:0] sec, input logic [7:0] exp_status,
                           input int exp_cycles, input int exp_writes, input bit expect_rd);
        int cnt;
        int rd0;
        int wr0;
        bit done;
        @(posedge clk);
        #1;
        rd0 = rd_seen;
        wr0 = wr_seen;
        track = trk;
        sector = sec;
        cpu_command = cmd;
        cnt = 0;
        done = 1'b0;
        for (int i = 0; i < 30000 && !done; i++) begin
            @(posedge clk);
            if (clken) cnt++;
            #1;
            if (cpu_status != 8'h00) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout status=%0h required=%0h", name, cpu_status, exp_status);
        end else begin
            checks++;
            if (cpu_status !== exp_status) begin
                errors++;
                $display("FAIL %s_status got %0h required %0h", name, cpu_status, exp_status);
            end
            if (exp_cycles > 0) begin
                checks++;
                if (cnt != exp_cycles) begin
                    errors++;
                    $display("FAIL %s_latency got %0d required %0d", name, cnt, exp_cycles);
                end
            end
        end
        checks++;
        if (wr_seen - wr0 != exp_writes || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL %s_writes got %0d left=%0d required %0d", name, wr_seen - wr0,
                     exp_wr_q.size(), exp_writes);
        end
        checks++;
        if ((rd_seen != rd0) !== expect_rd || exp_fetch_q.size() != 0) begin
            errors++;
            $display("FAIL %s_reads got rd_cycles=%0d left=%0d required rd=%0b", name,
                     rd_seen - rd0, exp_fetch_q.size(), expect_rd);
        end
    endtask

    task automatic send_ack(input string name);
        bit en;
        @(posedge clk);
        #1;
        cpu_command = 8'h80;
        en = 1'b0;
        for (int i = 0; i < 16 && !en; i++) begin
            @(posedge clk);
            en = clken;
        end
        #1;
        checks++;
        if (cpu_status !== 8'h00) begin
            errors++;
            $display("FAIL %s_ack_status got %0h required 00", name, cpu_status);
        end
        cpu_command = 8'h00;
    endtask

    task automatic test_reset();
        bit hit;
        mon_en = 1'b0;
        reset_n = 1'b0;
        cpu_command = 8'h00;
        cpu_command_s1 = 8'h00;
        track = 8'h00;
        sector = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cpu_status, img_rd, img_addr, buff_wr, buff_addr, buff_odata} !== '0) begin
            errors++;
            $display("FAIL reset_values got st=%0h rd=%0b ia=%0h wr=%0b ba=%0h bd=%0h required all 0",
                     cpu_status, img_rd, img_addr, buff_wr, buff_addr, buff_odata);
        end
        checks++;
        if ({cpu_status_s1, img_rd_s1, img_addr_s1, buff_wr_s1, buff_addr_s1,
             buff_odata_s1} !== '0) begin
            errors++;
            $display("FAIL reset_values_s1 got st=%0h ia=%0h ba=%0h bd=%0h required all 0",
                     cpu_status_s1, img_addr_s1, buff_addr_s1, buff_odata_s1);
        end
        reset_n = 1'b1;
        cpu_command = 8'h80;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (cpu_status !== 8'h00 || img_rd !== 1'b0 || buff_wr !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored got st=%0h rd=%0b wr=%0b required 00 0 0",
                     cpu_status, img_rd, buff_wr);
        end
        // Start a READ and pull reset mid-FETCH, between clock edges.
        cpu_command = 8'h10;
        track = 8'd0;
        sector = 8'd1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk);
            #1;
            hit = img_rd;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_fetch_start got rd=0 required 1");
        end
        repeat (4) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (img_rd !== 1'b0 || buff_wr !== 1'b0 || cpu_status !== 8'h00) begin
            errors++;
            $display("FAIL reset_async got rd=%0b wr=%0b st=%0h required 0 0 00",
                     img_rd, buff_wr, cpu_status);
        end
        cpu_command = 8'h00;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cpu_command = 8'h80;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cpu_status !== 8'h00 || img_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got st=%0h rd=%0b required 00 0", cpu_status, img_rd);
        end
        cpu_command = 8'h00;
        exp_wr_q.delete();
        exp_fetch_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic test_read_basic();
        push_read(8'd0, 8'd1, 1'b0);
        run_cmd("read_t0s1", 8'h10, 8'd0, 8'd1, 8'h03, 1026, 512, 1'b1);
        send_ack("read_t0s1");
    endtask

    task automatic test_read_offset();
        checks++;
        if (base_of(8'd5, 8'd10, 1'b1) !== 20'h0EE00) begin
            errors++;
            $display("FAIL model_base got %0h required 0ee00", base_of(8'd5, 8'd10, 1'b1));
        end
        push_read(8'd5, 8'd10, 1'b1);
        run_cmd("read_t5s10", 8'h11, 8'd5, 8'd10, 8'h03, 1026, 512, 1'b1);
        send_ack("read_t5s10");
    endtask

    task automatic test_invalid();
        int  cnt;
        bit  done;
        bit  traffic;
        run_cmd("inv_sec0", 8'h10, 8'd0, 8'd0, 8'h01, 2, 0, 1'b0);
        send_ack("inv_sec0");
        run_cmd("inv_sec11", 8'h10, 8'd0, 8'd11, 8'h01, 2, 0, 1'b0);
        send_ack("inv_sec11");
        run_cmd("inv_trk80", 8'h10, 8'd80, 8'd1, 8'h01, 2, 0, 1'b0);
        send_ack("inv_trk80");
        // Side 1 on the single-sided instance.
        @(posedge clk);
        #1;
        track = 8'd0;
        sector = 8'd1;
        cpu_command_s1 = 8'h11;
        cnt = 0;
        done = 1'b0;
        traffic = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            if (clken) cnt++;
            #1;
            if (img_rd_s1 || buff_wr_s1) traffic = 1'b1;
            if (cpu_status_s1 != 8'h00) done = 1'b1;
        end
        checks++;
        if (cpu_status_s1 !== 8'h01 || cnt != 2) begin
            errors++;
            $display("FAIL inv_side status=%0h cycles=%0d required 01 at 2", cpu_status_s1, cnt);
        end
        checks++;
        if (traffic) begin
            errors++;
            $display("FAIL inv_side_traffic got 1 required 0");
        end
        cpu_command_s1 = 8'h80;
        @(posedge clk);
        #1;
        cpu_command_s1 = 8'h00;
        checks++;
        if (cpu_status_s1 !== 8'h00) begin
            errors++;
            $display("FAIL inv_side_ack got %0h required 00", cpu_status_s1);
        end
    endtask

    task automatic test_readaddr();
        exp_wr_q.push_back({9'd0, 8'h22});
        exp_wr_q.push_back({9'd1, 8'h01});
        exp_wr_q.push_back({9'd2, 8'h03});
        exp_wr_q.push_back({9'd3, 8'h02});
        exp_wr_q.push_back({9'd4, 8'h00});
        exp_wr_q.push_back({9'd5, 8'h00});
        run_cmd("readaddr", 8'h31, 8'h22, 8'd3, 8'h03, 8, 6, 1'b0);
        send_ack("readaddr");
    endtask

    task automatic test_stress();
        @(negedge clk);
        stress = 1'b1;
        push_read(8'd79, 8'd10, 1'b1);
        run_cmd("stress_read", 8'h11, 8'd79, 8'd10, 8'h03, 0, 512, 1'b1);
    endtask

    // Follows test_stress with the READ code still asserted in DONE.
    task automatic test_back_to_back();
        int rd0;
        int wr0;
        int en;
        rd0 = rd_seen;
        wr0 = wr_seen;
        en = 0;
        for (int i = 0; i < 400 && en < 20; i++) begin
            @(posedge clk);
            if (clken) en++;
        end
        #1;
        checks++;
        if (cpu_status !== 8'h03 || rd_seen != rd0 || wr_seen != wr0) begin
            errors++;
            $display("FAIL done_hold got st=%0h rd=%0d wr=%0d required 03 0 0", cpu_status,
                     rd_seen - rd0, wr_seen - wr0);
        end
        send_ack("done_hold");
        push_read(8'd0, 8'd1, 1'b0);
        run_cmd("second_read", 8'h10, 8'd0, 8'd1, 8'h03, 0, 512, 1'b1);
        send_ack("second_read");
        @(negedge clk);
        stress = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_read_offset();
        test_invalid();
        test_readaddr();
        test_stress();
        test_back_to_back();
        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
